package_spi_tx: RTL
===================

Name: package_spi_tx

Overview:
Read-side drainer for the ping-pong package FIFO, running in the rd_clk domain. On each package_ready it reads exactly one package of bytes from the FIFO. It frames the bytes as header, sequence number, payload and checksum, and shifts the frame out as an SPI mode-0 master toward the wireless module. It is the consumer at the other end of the FIFO's package_ready/rd_en/valid interface.

Parameters:
DATA_WIDTH, 8, FIFO word width; fixed at 8 (payload is byte-serialised).
PACKAGE_SIZE, 60, data bytes per package (production value 38912).
CNT_WIDTH, 16, width of the payload byte counter; must satisfy 2^CNT_WIDTH > PACKAGE_SIZE.
CLK_DIV, 2, rd_clk cycles per SCLK half-period; legal range 1..255.
HEADER, 8'hA5, first byte of every frame.
VALID_TIMEOUT, 8, rd_clk cycles to wait for fifo_valid after rd_en.

Ports:
rd_clk  input  1  single clock, all logic on its rising edge.
rst  input  1  asynchronous active-high reset.
package_ready  input  1  from FIFO, wr_clk domain. Pulse at least one wr_clk wide; synchronised internally.
fifo_valid  input  1  FIFO read data valid.
fifo_dout  input  DATA_WIDTH  FIFO read data.
fifo_empty  input  1  FIFO empty flag.
rd_en  output  1  one-cycle read strobe to the FIFO.
spi_sclk  output  1  SPI clock, idles low (CPOL=0).
spi_cs_n  output  1  chip select, low for the whole frame.
spi_mosi  output  1  SPI data, MSB first, changes on SCLK falling edge.
busy  output  1  high from frame accept to end of GAP.
frame_done  output  1  one-cycle pulse after the checksum byte's last bit.
overrun  output  1  sticky; a package was lost. Cleared only by rst.
read_error  output  1  sticky; valid timeout or fifo_empty during payload. Cleared only by rst.
seq_num  output  8  sequence number of the current or last frame.

Behaviour:
- Reset (async, rst=1): every output goes to its idle value.
  - rd_en=0, spi_sclk=0, spi_cs_n=1, spi_mosi=0, busy=0, frame_done=0.
  - overrun=0, read_error=0, seq_num=0. Internal state goes to IDLE, pending=0.
  - Asserting rst mid-frame aborts at once; cs_n rises asynchronously.
- package_ready synchronisation and pending flag:
  - package_ready passes through a 2-flop synchroniser, then a rising-edge detector. Each detected edge is one request.
  - A request sets pending.
  - A request arriving while pending is already 1 and a frame is active sets overrun; the request is dropped.
- State machine:
  - IDLE: if pending, clear pending, assert busy, drop cs_n, load HEADER into the shifter, go to HDR.
  - HDR: shift the header byte.
  - SEQ: shift seq_num.
  - FETCH: pulse rd_en for exactly one cycle, go to WAIT_V.
  - WAIT_V: on fifo_valid, capture fifo_dout, add it to the checksum, go to DATA.
    - If no valid within VALID_TIMEOUT cycles, set read_error, substitute 8'h00, and continue.
    - If fifo_empty is sampled high in FETCH, set read_error, skip rd_en, and substitute 8'h00.
    - The frame length is always PACKAGE_SIZE + 3 bytes.
  - DATA: shift the byte, increment byte_cnt. Return to FETCH if byte_cnt < PACKAGE_SIZE, else go to CSUM.
  - CSUM: shift the checksum (8-bit sum of payload bytes, mod 256, header/seq excluded).
  - GAP: cs_n high for 2*CLK_DIV cycles, pulse frame_done, increment seq_num (wraps 255->0), drop busy, return to IDLE.
- Serialiser:
  - For each byte, MOSI is set to the MSB while SCLK is low.
  - SCLK toggles every CLK_DIV cycles: 8 rising edges per byte, 16*CLK_DIV rd_clk cycles per byte.
  - SCLK ends low after bit 0.
  - In WAIT_V, SCLK stays low and cs_n stays low; the payload stream may stall between bytes.
- Only one rd_en is outstanding at a time; rd_en never asserts outside FETCH.
- Simultaneous request and GAP end: the request sets pending, and the next frame starts on the following IDLE cycle.

Test Plan:
- Reset then one package_ready pulse, PACKAGE_SIZE=4, FIFO returns 01,02,03,04 with valid one cycle after rd_en.
  -> MOSI bytes A5,00,01,02,03,04,0A; exactly 4 rd_en pulses; frame_done once; seq_num=1.
- Payload FF,FF,FF,FF -> checksum FC (wrap); frame length is still 7 bytes.
- CLK_DIV=3 -> SCLK half-period 3 cycles; cs_n low for 7*48 cycles plus fetch stalls; data stable at every SCLK rise.
- Three package_ready pulses during one frame -> first sets pending, second sets overrun; exactly two frames, seq 00 then 01.
- fifo_valid never asserted for byte 2 -> read_error=1 after 8 cycles, byte 2 sent as 00, frame completes with correct length.
- rst asserted mid-DATA -> cs_n=1, sclk=0, rd_en=0 immediately; next request sends a clean frame with seq_num=00.

Source files
------------

// File: rtl/package_spi_tx.sv
// Drains one package per package_ready from the ping-pong FIFO and sends it as an SPI mode-0 frame:
// header, sequence number, payload, 8-bit checksum.
module package_spi_tx #(
    parameter int          DATA_WIDTH    = 8,
    parameter int          PACKAGE_SIZE  = 60,
    parameter int          CNT_WIDTH     = 16,
    parameter int          CLK_DIV       = 2,
    parameter logic [7:0]  HEADER        = 8'hA5,
    parameter int          VALID_TIMEOUT = 8
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  package_ready,
    input  logic                  fifo_valid,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  rd_en,
    output logic                  spi_sclk,
    output logic                  spi_cs_n,
    output logic                  spi_mosi,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  read_error,
    output logic [7:0]            seq_num
);

    localparam int WT_W  = $clog2(VALID_TIMEOUT + 1);
    localparam int GAP_W = $clog2(2 * CLK_DIV + 1);

    typedef enum logic [2:0] {IDLE, HDR, SEQ, FETCH, WAIT_V, DATA, CSUM, GAP} state_t;

    state_t                state, state_next;
    logic                  pr_meta, pr_sync, pr_prev;
    logic                  req, pending;
    logic [7:0]            div_cnt;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg, checksum;
    logic [CNT_WIDTH-1:0]  byte_cnt;
    logic [WT_W-1:0]       wait_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  shifting, div_last, byte_done, last_byte, timeout, gap_done;

    assign req       = pr_sync & ~pr_prev;
    assign shifting  = state inside {HDR, SEQ, DATA, CSUM};
    assign div_last  = (div_cnt == 8'(CLK_DIV - 1));
    assign byte_done = shifting && spi_sclk && div_last && (bit_cnt == 3'd7);
    assign last_byte = (byte_cnt == CNT_WIDTH'(PACKAGE_SIZE - 1));
    assign timeout   = (wait_cnt == WT_W'(VALID_TIMEOUT - 1));
    assign gap_done  = (gap_cnt == GAP_W'(2 * CLK_DIV - 1));

    // Decoded from state so an async reset releases cs_n and rd_en immediately.
    assign rd_en      = (state == FETCH) && !fifo_empty;
    assign spi_cs_n   = (state == IDLE) || (state == GAP);
    assign busy       = (state != IDLE);
    assign frame_done = (state == GAP) && gap_done;
    assign spi_mosi   = shreg[7];

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pending) state_next = HDR;
            HDR:     if (byte_done) state_next = SEQ;
            SEQ:     if (byte_done) state_next = FETCH;
            FETCH:   state_next = fifo_empty ? DATA : WAIT_V;
            WAIT_V:  if (fifo_valid || timeout) state_next = DATA;
            DATA:    if (byte_done) state_next = last_byte ? CSUM : FETCH;
            CSUM:    if (byte_done) state_next = GAP;
            GAP:     if (gap_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            pr_meta    <= 1'b0;
            pr_sync    <= 1'b0;
            pr_prev    <= 1'b0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            read_error <= 1'b0;
            seq_num    <= 8'd0;
            spi_sclk   <= 1'b0;
            div_cnt    <= 8'd0;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            checksum   <= 8'd0;
            byte_cnt   <= '0;
            wait_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            pr_meta <= package_ready;
            pr_sync <= pr_meta;
            pr_prev <= pr_sync;

            // A request landing on the accept cycle stays pending for the next frame.
            if (state == IDLE && pending) pending <= req;
            else if (req)                 pending <= 1'b1;
            if (req && pending && busy)   overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (pending) begin
                        shreg    <= HEADER;
                        checksum <= 8'd0;
                        byte_cnt <= '0;
                        div_cnt  <= 8'd0;
                        bit_cnt  <= 3'd0;
                        gap_cnt  <= '0;
                    end
                end
                HDR, SEQ, DATA, CSUM: begin
                    if (div_last) begin
                        div_cnt  <= 8'd0;
                        spi_sclk <= ~spi_sclk;
                        if (spi_sclk) begin
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                    // The next byte is loaded on the same edge that drops SCLK after bit 0.
                    if (byte_done) begin
                        if (state == HDR) shreg <= seq_num;
                        if (state == DATA) begin
                            byte_cnt <= byte_cnt + CNT_WIDTH'(1);
                            if (last_byte) shreg <= checksum;
                        end
                    end
                end
                FETCH: begin
                    wait_cnt <= '0;
                    if (fifo_empty) begin
                        read_error <= 1'b1;
                        shreg      <= 8'd0;
                    end
                end
                WAIT_V: begin
                    if (fifo_valid) begin
                        shreg    <= fifo_dout[7:0];
                        checksum <= checksum + fifo_dout[7:0];
                    end else if (timeout) begin
                        read_error <= 1'b1;
                        shreg      <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + WT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        gap_cnt <= '0;
                        seq_num <= seq_num + 8'd1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
